reg_status_file: RTL
====================

// Module: reg_status_file
// PURPOSE
//  Architectural register file plus per-register rename status (busy + ROB tag); consumer end of the ROB commit port.
//  Accepts ROB commit beats into a small commit queue and raises spare while it can take more.
//  Drains one commit per cycle into the array; clears busy only when the committing tag is still current.
//  Records issue-time renames and serves two dispatch read ports (value, busy, tag).
// PARAMETERS
//  XLEN      32  data width
//  NREG      32  register count; x0 hardwired to zero, never busy
//  TAG_W     4   ROB tag width
//  CQ_DEPTH  2   commit queue entries (power of two, >=2)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  rdy          in   1      global enable; when low all state holds and spare is driven 0
//  rob_ready    in   1      commit beat valid
//  rob_value    in   XLEN   committed value
//  rob_addr     in   5      destination register
//  rob_tag      in   TAG_W  ROB slot of the committing instruction
//  spare        out  1      commit queue not full (registered)
//  issue_valid  in   1      rename request
//  issue_rd     in   5      register being renamed
//  issue_tag    in   TAG_W  new producer tag
//  flush        in   1      clear all busy bits (misprediction recovery)
//  rs1_addr     in   5      read port 1 address
//  rs1_value    out  XLEN   read port 1 value (combinational)
//  rs1_busy     out  1      read port 1 pending producer
//  rs1_tag      out  TAG_W  read port 1 producer tag
//  rs2_addr/rs2_value/rs2_busy/rs2_tag   same as port 1
// BEHAVIOUR
//  Reset (async, rst_n=0): all regs 0, busy 0, tags 0, queue empty, spare 0; spare rises to 1 on first rdy cycle after release.
//  Commit accept: beat enqueued on posedge when rob_ready & spare & rdy; the ROB only sends while spare=1.
//  Beat arriving while full (protocol violation) is dropped; full status is unchanged.
//  spare = registered (count_next < CQ_DEPTH), so one beat per cycle stays lossless.
//  Drain: when queue non-empty, head popped every cycle: reg[addr] <= value (ignored if addr==0);
//   busy[addr] <= 0 only if busy[addr] && tag[addr]==head.tag.
//  Enqueue and dequeue in same cycle: count unchanged; pointers wrap modulo CQ_DEPTH.
//  Rename: issue_valid & rd!=0 -> busy[rd]<=1, tag[rd]<=issue_tag next edge.
//  Rename vs drain on same rd, same cycle: value written, rename wins (busy=1, tag=issue_tag).
//  flush: all busy<=0 next edge; queue entries are NOT discarded and still write values.
//   flush and issue_valid in the same cycle: flush wins, no rename recorded.
//  Reads: combinational from array/status; addr 0 -> value 0, busy 0, tag 0.
//  Latency: commit beat -> array write 1 cycle after enqueue when queue was empty.
// CONFIGURATION
//  COMMIT_BYPASS_EN defined: read port whose addr matches the draining head (addr!=0) returns head.value;
//   busy forced 0 when tag[addr]==head.tag and no same-cycle rename targets that addr.
//  Undefined: reads reflect array state only; draining value visible the cycle after the write.
// STRUCTURE
//  Shared package/constants: XLEN, TAG_W, REG_ADDR_W=5, commit-beat struct {addr,value,tag}, True/False.
//  One sub-module: commit_queue (parametric FIFO, push/pop/count/full/empty); register array and status stay top-level.
// TESTING
//  Reset: rst_n=0 mid-run with 2 queued beats -> queue empty, all busy 0; spare=1 the cycle after release with rdy=1.
//  Rename x5 tag 3, commit {x5,0xDEADBEEF,3} -> after drain rs1(x5) = 0xDEADBEEF, busy 0.
//  Stale commit: rename x7 tag 2 then x7 tag 9; commit {x7,0x11,2} -> value 0x11, busy 1, tag 9.
//  Back-to-back: 3 commits on consecutive cycles, CQ_DEPTH=2 -> spare never drops 1->lost; all 3 written in order.
//  Same-cycle rename+drain on x3 (new tag 4) -> busy 1, tag 4, value updated; flush next cycle -> busy 0.
//  x0: rename x0 and commit {x0,0x55,1} -> rs1(x0)=0, busy 0; bypass build: matching read returns value same cycle.

Source files
------------

// File: rtl/reg_status_file_pkg.sv
// Shared constants and payload types for the architectural register/status file.
// Holds data/tag widths, the commit-beat payload, the read-port response and a
// small helper that identifies writable (non-x0) registers.
package reg_status_file_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NREG         = 32;
   localparam int unsigned TAG_W        = 4;
   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned CQ_DEPTH_DEF = 2;

   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;

   // One ROB commit beat as carried through the commit queue.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       value;
      logic [TAG_W-1:0]      tag;
   } commit_beat_t;

   localparam int unsigned BEAT_W = $bits(commit_beat_t);

   // What a dispatch read port returns for one source register.
   typedef struct packed {
      logic [XLEN-1:0]  value;
      logic             busy;
      logic [TAG_W-1:0] tag;
   } rd_resp_t;

   // x0 is hardwired: never written, never renamed.
   function automatic logic is_arch_reg(input logic [REG_ADDR_W-1:0] addr);
      return addr != REG_ADDR_W'(0);
   endfunction

endpackage

// File: rtl/reg_status_file_commit_queue.sv
// Parametric FIFO buffering commit beats between the ROB and the register array.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      enqueue request and payload (ignored while full)
//   pop            dequeue request (ignored while empty)
//   dout_c         head entry, combinational from storage
//   count          registered occupancy
//   full_c/empty_c occupancy flags derived from count
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module reg_status_file_commit_queue #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout_c,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full_c,
   output logic                         empty_c
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic             do_push_c;
   logic             do_pop_c;

   assign full_c    = (count == CNT_W'(DEPTH));
   assign empty_c   = (count == CNT_W'(0));
   assign do_push_c = push & ~full_c;
   assign do_pop_c  = pop & ~empty_c;
   assign dout_c    = mem_q[rd_ptr_q];

   // Payload storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count    <= '0;
      end else begin
         if (do_push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      end
   end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Consumes ROB commit beats through a small commit queue, drains one beat per
// cycle into the array, records issue-time renames and serves two read ports.
// Optional feature: define COMMIT_BYPASS_EN to forward the draining head beat
// to a matching read port in the same cycle.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   rdy                                global enable; low holds all state, spare goes 0
//   rob_ready/rob_value/rob_addr/rob_tag  commit beat
//   spare                              commit queue can take a beat (registered)
//   issue_valid/issue_rd/issue_tag     rename request
//   flush                              clear every busy bit
//   rs1_addr -> rs1_value/busy/tag     read port 1 (combinational)
//   rs2_addr -> rs2_value/busy/tag     read port 2 (combinational)
module reg_status_file
   import reg_status_file_pkg::*;
#(
   parameter int unsigned CQ_DEPTH = CQ_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdy,
   input  logic                  rob_ready,
   input  logic [XLEN-1:0]       rob_value,
   input  logic [REG_ADDR_W-1:0] rob_addr,
   input  logic [TAG_W-1:0]      rob_tag,
   output logic                  spare,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [TAG_W-1:0]      issue_tag,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [XLEN-1:0]       rs1_value,
   output logic                  rs1_busy,
   output logic [TAG_W-1:0]      rs1_tag,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs2_value,
   output logic                  rs2_busy,
   output logic [TAG_W-1:0]      rs2_tag
);

   localparam int unsigned CNT_W  = $clog2(CQ_DEPTH + 1);
   localparam int unsigned NPORTS = 2;

   logic [XLEN-1:0]       regs_q [NREG];
   logic [TAG_W-1:0]      tag_q  [NREG];
   logic [NREG-1:0]       busy_q;
   logic [NREG-1:0]       busy_nxt_c;

   commit_beat_t          in_beat_c;
   commit_beat_t          head_c;
   logic [BEAT_W-1:0]     head_bits_c;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_next_c;
   logic                  full_c;
   logic                  empty_c;
   logic                  push_c;
   logic                  pop_c;
   logic                  drain_wr_c;
   logic                  drain_clr_c;
   logic                  ren_c;

   logic [REG_ADDR_W-1:0] rd_addr_c [NPORTS];
   rd_resp_t              rd_resp_c [NPORTS];

   // Commit queue ---------------------------------------------------------
   assign in_beat_c.addr  = rob_addr;
   assign in_beat_c.value = rob_value;
   assign in_beat_c.tag   = rob_tag;

   // The full check only matters for a ROB that ignores spare: such a beat is dropped.
   assign push_c = rdy & rob_ready & spare & ~full_c;
   assign pop_c  = rdy & ~empty_c;

   reg_status_file_commit_queue #(
      .W     (BEAT_W),
      .DEPTH (CQ_DEPTH)
   ) u_commit_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_c),
      .din     (in_beat_c),
      .pop     (pop_c),
      .dout_c  (head_bits_c),
      .count   (count),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   assign head_c       = commit_beat_t'(head_bits_c);
   assign count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);

   // spare looks at next-cycle occupancy so a beat every cycle never overflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spare <= False;
      end else if (rdy) begin
         spare <= (count_next_c < CNT_W'(CQ_DEPTH));
      end else begin
         spare <= False;
      end
   end

   // Drain and rename decode ----------------------------------------------
   assign drain_wr_c  = pop_c & is_arch_reg(head_c.addr);
   // Only the producer that is still current may clear busy.
   assign drain_clr_c = drain_wr_c & busy_q[head_c.addr] &
                        (tag_q[head_c.addr] == head_c.tag);
   assign ren_c       = rdy & issue_valid & ~flush & is_arch_reg(issue_rd);

   // Busy update: flush beats everything, a rename beats a same-cycle clear.
   always_comb begin
      busy_nxt_c = busy_q;
      if (flush) begin
         busy_nxt_c = '0;
      end else begin
         if (drain_clr_c) begin
            busy_nxt_c[head_c.addr] = False;
         end
         if (ren_c) begin
            busy_nxt_c[issue_rd] = True;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else if (rdy) begin
         busy_q <= busy_nxt_c;
      end
   end

   // Register values and producer tags; enables already include rdy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         if (drain_wr_c) begin
            regs_q[head_c.addr] <= head_c.value;
         end
         if (ren_c) begin
            tag_q[issue_rd] <= issue_tag;
         end
      end
   end

   // Read ports -------------------------------------------------------------
   assign rd_addr_c[0] = rs1_addr;
   assign rd_addr_c[1] = rs2_addr;

   always_comb begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
         rd_resp_c[p] = '0;
         if (is_arch_reg(rd_addr_c[p])) begin
            rd_resp_c[p].value = regs_q[rd_addr_c[p]];
            rd_resp_c[p].busy  = busy_q[rd_addr_c[p]];
            rd_resp_c[p].tag   = tag_q[rd_addr_c[p]];
`ifdef COMMIT_BYPASS_EN
            // Forward the beat being written this cycle.
            if (pop_c && (head_c.addr == rd_addr_c[p])) begin
               rd_resp_c[p].value = head_c.value;
               if ((tag_q[rd_addr_c[p]] == head_c.tag) &&
                   !(ren_c && (issue_rd == rd_addr_c[p]))) begin
                  rd_resp_c[p].busy = False;
               end
            end
`endif
         end
      end
   end

   assign rs1_value = rd_resp_c[0].value;
   assign rs1_busy  = rd_resp_c[0].busy;
   assign rs1_tag   = rd_resp_c[0].tag;
   assign rs2_value = rd_resp_c[1].value;
   assign rs2_busy  = rd_resp_c[1].busy;
   assign rs2_tag   = rd_resp_c[1].tag;

endmodule
